bf16_fma_sched: RTL
===================

# bf16_fma_sched

Issue controller for the BF16 fused multiply-add datapath. It accepts BF16 arithmetic requests over a valid/ready handshake and maps `funct5` to FMA operands (add/sub, mul, fmadd/fmsub). It issues at most one operation per cycle into a fixed-latency FMA pipeline and tracks in-flight operations in a shadow pipe. Results are buffered in an in-order response FIFO with credit-based backpressure, and a flush/drain sequence is provided for the core.

## Interface
Parameters:
- `LAT`, 3: FMA datapath latency, in cycles, from `fma_valid` to `fma_res`; must be ≥1.
- `DEPTH`, 8: response FIFO depth and credit limit; a power of 2, ≥2.

Ports:
- `clk`  in  1  — the only clock.
- `rst_n`  in  1  — asynchronous reset, active-low.
- `req_valid`  in  1  — request valid.
- `req_ready`  out  1  — request accepted when `req_valid && req_ready`.
- `req_funct5`  in  5  — operation code.
- `req_in1`, `req_in2`, `req_in3`  in  16 each  — BF16 source operands.
- `fma_valid`  out  1  — issue strobe to the datapath.
- `fma_funct5`  out  5  — operation code forwarded to the datapath, for add/sub and fmadd/fmsub sign control.
- `fma_a`, `fma_b`, `fma_c`  out  16 each  — datapath operands; the datapath computes a*b+c.
- `fma_res`  in  16  — datapath result, valid exactly `LAT` cycles after `fma_valid`.
- `rsp_valid`  out  1  — response valid.
- `rsp_ready`  in  1  — response consumed when `rsp_valid && rsp_ready`.
- `rsp_data`  out  16  — BF16 result.
- `rsp_err`  out  1  — set for an illegal `funct5`.
- `flush_req`  in  1  — level; requests a drain.
- `flush_done`  out  1  — one-cycle pulse when the drain completes.

## Operation
- Decode, applied at acceptance:
  - `00000` and `00001`: a=in1, b=0x3F80, c=in2.
  - `00010`: a=in1, b=in2, c=0x0000.
  - `00100` and `00101`: a=in1, b=in2, c=in3.
  - Any other code is illegal.
- Illegal op handling:
  - `fma_valid` stays 0 and a/b/c are driven to 0.
  - The op still occupies a shadow slot and a credit, so response order is preserved.
  - Response is `rsp_err=1`, `rsp_data=0x0000`.
- Shadow pipe: `LAT` stages, each holding {valid, err}.
  - When stage `LAT` is valid, {err ? 0 : `fma_res`, err} is written into the FIFO.
- Credits: `outstanding` counts ops accepted but not yet popped from the FIFO.
  - `req_ready = (state==RUN) && outstanding < DEPTH`.
  - There is no combinational path from `rsp_ready` to `req_ready`.
  - A simultaneous accept and pop leaves `outstanding` unchanged.
  - Consequence: the FIFO can never overflow, and the datapath is never stalled.
- State machine:
  - RUN → DRAIN when `flush_req=1`. In that cycle `req_ready` is already 0.
  - DRAIN: no new accepts; the shadow pipe and FIFO drain normally through `rsp_ready`.
  - DRAIN → DONE when `outstanding==0`.
  - DONE: `flush_done=1` for one cycle, then → RUN. If `flush_req` is still high, → DRAIN again.
- Reset state: state RUN, shadow pipe cleared, FIFO empty, `outstanding=0`.
- Output values during reset: `req_ready=0`, then 1 from the first cycle after deassertion. All of `fma_*`, `rsp_*` and `flush_done` are 0.
- Reset asserted mid-operation drops all in-flight ops and responses. Nothing is replayed.

## Timing
- Request accepted at edge t:
  - `fma_valid`, `fma_a/b/c` and `fma_funct5` are registered and asserted during cycle t+1.
  - `fma_res` is sampled at the end of cycle t+1+`LAT`.
  - `rsp_valid` is asserted in cycle t+2+`LAT`.
  - Minimum accept-to-response latency is `LAT`+2 cycles.
- Throughput: one op per cycle while `rsp_ready=1`, provided `DEPTH` ≥ `LAT`+2.
- `rsp_*` are stable while `rsp_valid && !rsp_ready`.
- Credits are returned in the cycle after a pop.

## Configuration
- Macro: `BF16_SCHED_PERF_EN`.
- Defined:
  - Adds outputs `perf_issued[31:0]` (legal ops issued) and `perf_stall[31:0]` (cycles with `req_valid && !req_ready`).
  - Both are reset to 0, wrap modulo 2^32, and are not cleared by a flush.
- Undefined: those ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Package `bf16_pkg`:
  - `funct5` constants `F5_ADD=00000`, `F5_SUB=00001`, `F5_MUL=00010`, `F5_FMADD=00100`, `F5_FMSUB=00101`.
  - `BF16_ONE=16'h3F80`, `BF16_ZERO=16'h0000`.
  - State enum {RUN, DRAIN, DONE}.
- Sub-module `bf16_rsp_fifo`:
  - 17-bit wide (data + err), `DEPTH` entries, synchronous push/pop, asynchronous active-low reset.
  - Outputs `empty` and `count`.

## Test plan
Run with `LAT=3`, `DEPTH=8` and a behavioural FMA model.
- ADD: `funct5=00000`, in1=0x3F80, in2=0x4000 → issue a=0x3F80, b=0x3F80, c=0x4000 at t+1; `rsp_data=0x4040`, `rsp_err=0` at t+5.
- MUL then FMADD back-to-back:
  - MUL 0x4000, 0x4040 → 0x40C0.
  - FMADD 0x4000, 0x4040, 0x3F80 → 0x40E0.
  - Responses arrive on consecutive cycles, in order.
- Illegal `funct5=00011` between two ADDs:
  - `fma_valid` stays 0 in its slot.
  - Middle response is `rsp_err=1`, `rsp_data=0x0000`; order is preserved.
- Backpressure: `rsp_ready=0`, 10 requests presented.
  - Exactly 8 are accepted, then `req_ready=0`.
  - After `rsp_ready=1`, all 8 return in order and the remaining 2 are accepted.
- Flush: raise `flush_req` with 3 ops in flight.
  - `req_ready=0` immediately.
  - 3 responses are delivered.
  - `flush_done` pulses once, then `req_ready=1`.
- Reset mid-stream: assert `rst_n=0` with 4 ops outstanding.
  - All outputs go to 0 at once.
  - After release, no stale `rsp_valid` appears and the first new op returns at t+5.

Source files
------------

// File: rtl/bf16_pkg.sv
// bf16_pkg -- shared definitions for the BF16 FMA issue controller.
//   * funct5 operation codes understood by the scheduler
//   * BF16 constants used when building datapath operands
//   * scheduler state enum and the decoded-operand struct
//   * bf16_decode(): maps a request onto the a*b+c operand triple
package bf16_pkg;

    localparam logic [4:0] F5_ADD   = 5'b00000;
    localparam logic [4:0] F5_SUB   = 5'b00001;
    localparam logic [4:0] F5_MUL   = 5'b00010;
    localparam logic [4:0] F5_FMADD = 5'b00100;
    localparam logic [4:0] F5_FMSUB = 5'b00101;

    localparam logic [15:0] BF16_ONE  = 16'h3F80;
    localparam logic [15:0] BF16_ZERO = 16'h0000;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic        legal;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
    } fma_ops_t;

    // Every operation is expressed as a*b+c: add/sub multiply by one,
    // mul adds zero. Illegal codes come back with all operands zero.
    function automatic fma_ops_t bf16_decode(input logic [4:0]  f5,
                                             input logic [15:0] in1,
                                             input logic [15:0] in2,
                                             input logic [15:0] in3);
        fma_ops_t r;
        r = '0;
        case (f5)
            F5_ADD, F5_SUB: begin
                r.legal = 1'b1;
                r.a     = in1;
                r.b     = BF16_ONE;
                r.c     = in2;
            end
            F5_MUL: begin
                r.legal = 1'b1;
                r.a     = in1;
                r.b     = in2;
                r.c     = BF16_ZERO;
            end
            F5_FMADD, F5_FMSUB: begin
                r.legal = 1'b1;
                r.a     = in1;
                r.b     = in2;
                r.c     = in3;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bf16_rsp_fifo.sv
// bf16_rsp_fifo -- in-order response buffer ({err, data}) for the scheduler.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, push_data   write one entry (caller guarantees space via credits)
//   pop               consume the head entry (ignored while empty)
//   pop_data          head entry, valid while !empty
//   empty, count      occupancy status
module bf16_rsp_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 17
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_pop;

    assign do_pop   = pop && (cnt != '0);
    assign pop_data = mem[rd_ptr];
    assign empty    = (cnt == '0);
    assign count    = cnt;

    // Storage carries no reset; entries are only observed once written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/bf16_fma_sched.sv
// bf16_fma_sched -- issue controller for the BF16 fused multiply-add datapath.
// Decodes requests into a*b+c operands, issues at most one op per cycle into a
// LAT-cycle FMA pipe, tracks in-flight ops in a shadow pipe and returns results
// in order through a credit-protected response FIFO. Offers a flush/drain.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   req_valid/req_ready               request handshake
//   req_funct5, req_in1..3            operation code and BF16 operands
//   fma_valid, fma_funct5, fma_a/b/c  registered issue to the datapath
//   fma_res                           datapath result, LAT cycles after issue
//   rsp_valid/rsp_ready               response handshake
//   rsp_data, rsp_err                 BF16 result, illegal-opcode flag
//   flush_req, flush_done             drain request (level), completion pulse
//   dbg_state                         current scheduler state (state_t)
//   perf_issued, perf_stall           only when BF16_SCHED_PERF_EN is defined
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; valid must not depend on ready, and a presented response holds its
// payload until it is taken.
module bf16_fma_sched
    import bf16_pkg::*;
#(
    parameter int LAT   = 3,
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_funct5,
    input  logic [15:0] req_in1,
    input  logic [15:0] req_in2,
    input  logic [15:0] req_in3,
    output logic        fma_valid,
    output logic [4:0]  fma_funct5,
    output logic [15:0] fma_a,
    output logic [15:0] fma_b,
    output logic [15:0] fma_c,
    input  logic [15:0] fma_res,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    input  logic        flush_req,
    output logic        flush_done,
    output logic [1:0]  dbg_state
`ifdef BF16_SCHED_PERF_EN
    ,
    output logic [31:0] perf_issued,
    output logic [31:0] perf_stall
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t        state;
    logic [CW-1:0] outstanding;
    fma_ops_t      dec;
    logic          accept;
    logic          issue_legal;
    logic          pop;

    // Issue-stage bookkeeping, aligned with the fma_* registers.
    logic          iss_v;
    logic          iss_err;
    // Shadow stage LAT lines up with fma_res for the op it describes.
    logic [LAT:1]  sh_v;
    logic [LAT:1]  sh_err;

    logic          fifo_push;
    logic [16:0]   fifo_push_data;
    logic [16:0]   fifo_head;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    assign dec         = bf16_decode(req_funct5, req_in1, req_in2, req_in3);
    // Depends only on registered state and flush_req, never on rsp_ready.
    // Gated by rst_n so the request side is closed while reset is held.
    assign req_ready   = rst_n && (state == RUN) && !flush_req &&
                         (outstanding < CW'(DEPTH));
    assign accept      = req_valid && req_ready;
    assign issue_legal = accept && dec.legal;
    assign dbg_state   = state;

    assign rsp_valid   = (fifo_count != '0);
    assign pop         = rsp_valid && rsp_ready;
    assign rsp_err     = fifo_empty ? 1'b0 : fifo_head[16];
    assign rsp_data    = fifo_empty ? BF16_ZERO : fifo_head[15:0];

    assign fifo_push      = sh_v[LAT];
    assign fifo_push_data = {sh_err[LAT], sh_err[LAT] ? BF16_ZERO : fma_res};

    // Datapath issue, shadow pipe and credit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fma_valid   <= 1'b0;
            fma_funct5  <= 5'd0;
            fma_a       <= BF16_ZERO;
            fma_b       <= BF16_ZERO;
            fma_c       <= BF16_ZERO;
            iss_v       <= 1'b0;
            iss_err     <= 1'b0;
            sh_v        <= '0;
            sh_err      <= '0;
            outstanding <= '0;
        end else begin
            fma_valid  <= issue_legal;
            fma_funct5 <= issue_legal ? req_funct5 : 5'd0;
            fma_a      <= issue_legal ? dec.a : BF16_ZERO;
            fma_b      <= issue_legal ? dec.b : BF16_ZERO;
            fma_c      <= issue_legal ? dec.c : BF16_ZERO;

            // Illegal ops still travel the pipe so responses stay in order.
            iss_v   <= accept;
            iss_err <= accept && !dec.legal;

            sh_v[1]   <= iss_v;
            sh_err[1] <= iss_err;
            for (int i = 2; i <= LAT; i++) begin
                sh_v[i]   <= sh_v[i-1];
                sh_err[i] <= sh_err[i-1];
            end

            case ({accept, pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Flush sequencing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            case (state)
                RUN: begin
                    if (flush_req) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (outstanding == '0) begin
                        state      <= DONE;
                        flush_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= flush_req ? DRAIN : RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef BF16_SCHED_PERF_EN
    // Free-running counters; a flush leaves them alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (issue_legal) begin
                perf_issued <= perf_issued + 32'd1;
            end
            if (req_valid && !req_ready) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

    // Credits bound occupancy to DEPTH, so push never finds the FIFO full.
    bf16_rsp_fifo #(
        .DEPTH (DEPTH),
        .W     (17)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (pop),
        .pop_data  (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule
